// File: rtl/addsub_serial_unit.sv
// ---------------------------------------------------------------------------
// addsub_serial_unit
//
// Two's-complement add / subtract / accumulate unit with registered operands.
// The arithmetic is digit-serial: DIGIT_W bits are summed per clock, LSB
// first, so an operation takes STEPS = WIDTH/DIGIT_W clocks after start.
// Signed overflow, unsigned carry-out, a sticky overflow flag and optional
// saturation of the result are provided.
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   data_in    operand data for loads
//   load_a     capture data_in into A (IDLE only)
//   load_b     capture data_in into B (IDLE only)
//   op         00 ADD A+B, 01 SUB A-B, 10 ACC result+B, 11 ACCSUB result-B
//   start      begin an operation (IDLE only)
//   clr_ovf    clear the sticky overflow flag
//   busy       high while the serial calculation runs
//   done       one-cycle pulse when result/flags update
//   result     last completed result
//   carry_out  unsigned carry of last operation (SUB: 1 = no borrow)
//   overflow   signed overflow of last operation
//   ovf_sticky set by any overflow since the last clear or reset
//   reg_a      current A register
//   reg_b      current B register
// ---------------------------------------------------------------------------
module addsub_serial_unit #(
    parameter int WIDTH    = 8,
    parameter int DIGIT_W  = 2,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             clr_ovf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b
);

    localparam int STEPS = WIDTH / DIGIT_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    // One digit of the ripple sum: DIGIT_W result bits plus the carry out.
    function automatic logic [DIGIT_W:0] digit_add(
        input logic [DIGIT_W-1:0] xd,
        input logic [DIGIT_W-1:0] yd,
        input logic               cin
    );
        digit_add = {1'b0, xd} + {1'b0, yd} + {{DIGIT_W{1'b0}}, cin};
    endfunction

    // Clamp value for a signed overflow; the sign of X gives the direction.
    function automatic logic [WIDTH-1:0] saturate_value(input logic neg);
        saturate_value = neg ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   x_r;         // X operand, shifted right one digit per step
    logic [WIDTH-1:0]   y_r;         // Y operand (already inverted for subtract)
    logic [WIDTH-1:0]   sum_r;       // partial sum, digits enter at the top
    logic               carry_r;
    logic [CNT_W-1:0]   step_r;
    logic               x_msb_r;     // operand sign bits kept for overflow
    logic               y_msb_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_out_r;
    logic               overflow_r;
    logic               ovf_sticky_r;

    logic [DIGIT_W:0]   digit_s;
    logic [WIDTH-1:0]   sum_next_s;
    logic               ovf_s;
    logic [WIDTH-1:0]   final_s;
    logic               last_step_s;
    logic [WIDTH-1:0]   x_start_s;
    logic [WIDTH-1:0]   y_start_s;

    // Operand selection at the start edge.
    always_comb begin
        x_start_s = op[1] ? result_r : a_r;
        y_start_s = op[0] ? ~b_r : b_r;
    end

    // Current digit sum, next partial sum and the finishing values.
    always_comb begin
        digit_s     = digit_add(x_r[DIGIT_W-1:0], y_r[DIGIT_W-1:0], carry_r);
        // After STEPS shifts the first digit has reached bit 0.
        sum_next_s  = (sum_r >> DIGIT_W)
                    | (WIDTH'(digit_s[DIGIT_W-1:0]) << (WIDTH - DIGIT_W));
        ovf_s       = (x_msb_r == y_msb_r) && (sum_next_s[WIDTH-1] != x_msb_r);
        last_step_s = (state_r == ST_CALC) && (step_r == LAST_STEP);
        if ((SATURATE != 0) && ovf_s) begin
            final_s = saturate_value(x_msb_r);
        end else begin
            final_s = sum_next_s;
        end
    end

    // Control FSM, operand registers, serial datapath and result flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            a_r          <= '0;
            b_r          <= '0;
            x_r          <= '0;
            y_r          <= '0;
            sum_r        <= '0;
            carry_r      <= 1'b0;
            step_r       <= '0;
            x_msb_r      <= 1'b0;
            y_msb_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            result_r     <= '0;
            carry_out_r  <= 1'b0;
            overflow_r   <= 1'b0;
            ovf_sticky_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Loads and start share the edge: start sees the old A/B.
                    if (load_a) begin
                        a_r <= data_in;
                    end
                    if (load_b) begin
                        b_r <= data_in;
                    end
                    if (start) begin
                        x_r     <= x_start_s;
                        y_r     <= y_start_s;
                        x_msb_r <= x_start_s[WIDTH-1];
                        y_msb_r <= y_start_s[WIDTH-1];
                        carry_r <= op[0];
                        sum_r   <= '0;
                        step_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    x_r     <= x_r >> DIGIT_W;
                    y_r     <= y_r >> DIGIT_W;
                    sum_r   <= sum_next_s;
                    carry_r <= digit_s[DIGIT_W];
                    if (last_step_s) begin
                        result_r    <= final_s;
                        carry_out_r <= digit_s[DIGIT_W];
                        overflow_r  <= ovf_s;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        step_r      <= '0;
                        state_r     <= ST_IDLE;
                    end else begin
                        step_r <= step_r + CNT_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
            // A fresh overflow wins over a simultaneous clear.
            if (last_step_s && ovf_s) begin
                ovf_sticky_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky_r <= 1'b0;
            end else begin
                ovf_sticky_r <= ovf_sticky_r;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;
    assign carry_out  = carry_out_r;
    assign overflow   = overflow_r;
    assign ovf_sticky = ovf_sticky_r;
    assign reg_a      = a_r;
    assign reg_b      = b_r;

endmodule

// File: tb/tb_addsub_serial_unit.sv
// ---------------------------------------------------------------------------
// Testbench for addsub_serial_unit. Four instances share the stimulus:
// the default build (DIGIT_W=2), a saturating build, and DIGIT_W=1 / 8 builds.
// Expected values come from a plain integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_addsub_serial_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] data_in;
    logic       load_a, load_b, start, clr_ovf;
    logic [1:0] op;

    logic       m_busy, m_done, m_carry, m_ovf, m_sticky;
    logic [7:0] m_result, m_reg_a, m_reg_b;
    logic       s_busy, s_done, s_carry, s_ovf, s_sticky;
    logic [7:0] s_result, s_reg_a, s_reg_b;
    logic       d1_busy, d1_done, d1_carry, d1_ovf, d1_sticky;
    logic [7:0] d1_result, d1_reg_a, d1_reg_b;
    logic       d8_busy, d8_done, d8_carry, d8_ovf, d8_sticky;
    logic [7:0] d8_result, d8_reg_a, d8_reg_b;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_res = 8'h00;   // model of the main unit's result register

    always #5 CLK = ~CLK;

    addsub_serial_unit #(.WIDTH(8), .DIGIT_W(2), .SATURATE(0)) dut (
        .CLK(CLK), .RST(RST), .data_in(data_in), .load_a(load_a), .load_b(load_b),
        .op(op), .start(start), .clr_ovf(clr_ovf), .busy(m_busy), .done(m_done),
        .result(m_result), .carry_out(m_carry), .overflow(m_ovf),
        .ovf_sticky(m_sticky), .reg_a(m_reg_a), .reg_b(m_reg_b));

    addsub_serial_unit #(.WIDTH(8), .DIGIT_W(2), .SATURATE(1)) dut_sat (
        .CLK(CLK), .RST(RST), .data_in(data_in), .load_a(load_a), .load_b(load_b),
        .op(op), .start(start), .clr_ovf(clr_ovf), .busy(s_busy), .done(s_done),
        .result(s_result), .carry_out(s_carry), .overflow(s_ovf),
        .ovf_sticky(s_sticky), .reg_a(s_reg_a), .reg_b(s_reg_b));

    addsub_serial_unit #(.WIDTH(8), .DIGIT_W(1), .SATURATE(0)) dut_d1 (
        .CLK(CLK), .RST(RST), .data_in(data_in), .load_a(load_a), .load_b(load_b),
        .op(op), .start(start), .clr_ovf(clr_ovf), .busy(d1_busy), .done(d1_done),
        .result(d1_result), .carry_out(d1_carry), .overflow(d1_ovf),
        .ovf_sticky(d1_sticky), .reg_a(d1_reg_a), .reg_b(d1_reg_b));

    addsub_serial_unit #(.WIDTH(8), .DIGIT_W(8), .SATURATE(0)) dut_d8 (
        .CLK(CLK), .RST(RST), .data_in(data_in), .load_a(load_a), .load_b(load_b),
        .op(op), .start(start), .clr_ovf(clr_ovf), .busy(d8_busy), .done(d8_done),
        .result(d8_result), .carry_out(d8_carry), .overflow(d8_ovf),
        .ovf_sticky(d8_sticky), .reg_a(d8_reg_a), .reg_b(d8_reg_b));

    typedef struct packed {
        logic       carry;
        logic       ovf;
        logic [7:0] res;
        logic [7:0] sat;
    } ref_t;

    // Reference: exact integer arithmetic, then wrap / range checks.
    function automatic ref_t ref_op(input logic [1:0] o, input logic [7:0] a,
                                    input logic [7:0] b, input logic [7:0] prev);
        ref_t r;
        int xu, bu, xs, bs, tu, ts;
        xu = o[1] ? int'(prev) : int'(a);
        xs = o[1] ? int'($signed(prev)) : int'($signed(a));
        bu = int'(b);
        bs = int'($signed(b));
        if (o[0]) begin
            tu = xu - bu; ts = xs - bs; r.carry = (xu >= bu);
        end else begin
            tu = xu + bu; ts = xs + bs; r.carry = (tu > 255);
        end
        r.res = tu[7:0];
        r.ovf = (ts > 127) || (ts < -128);
        r.sat = (ts > 127) ? 8'h7F : ((ts < -128) ? 8'h80 : tu[7:0]);
        return r;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        data_in = a; load_a = 1'b1; tick(); load_a = 1'b0;
        data_in = b; load_b = 1'b1; tick(); load_b = 1'b0;
    endtask

    // Start an operation and watch 12 cycles, recording first-done latencies.
    task automatic run_op(input logic [1:0] o, output int lat_m, output int lat_1,
                          output int lat_8, output int dcnt);
        op = o; start = 1'b1; tick(); start = 1'b0;
        lat_m = -1; lat_1 = -1; lat_8 = -1; dcnt = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (m_done) begin dcnt++; if (lat_m < 0) lat_m = n; end
            if (d1_done && lat_1 < 0) lat_1 = n;
            if (d8_done && lat_8 < 0) lat_8 = n;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; data_in = 8'h00; load_a = 1'b0; load_b = 1'b0;
        start = 1'b0; clr_ovf = 1'b0; op = 2'b00;
        tick(); tick();
        tests_run++;
        if ({m_busy, m_done, m_carry, m_ovf, m_sticky} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {m_busy, m_done, m_carry, m_ovf, m_sticky});
        end
        tests_run++;
        if ({m_result, m_reg_a, m_reg_b} !== 24'h000000) begin
            tests_failed++;
            $display("FAIL reset_regs: got %h expected 000000", {m_result, m_reg_a, m_reg_b});
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_add_overflow;
        ref_t r;
        int lm, l1, l8, dc;
        load_ab(8'h7F, 8'h01);
        r = ref_op(2'b00, 8'h7F, 8'h01, exp_res);
        run_op(2'b00, lm, l1, l8, dc);
        exp_res = r.res;
        tests_run++;
        if (lm !== 4) begin tests_failed++; $display("FAIL add_latency: got %0d expected 4", lm); end
        tests_run++;
        if ({m_carry, m_ovf, m_result} !== {r.carry, r.ovf, r.res}) begin
            tests_failed++;
            $display("FAIL add_ovf: got c=%b o=%b r=%h expected c=%b o=%b r=%h",
                     m_carry, m_ovf, m_result, r.carry, r.ovf, r.res);
        end
        tests_run++;
        if (m_sticky !== 1'b1) begin tests_failed++; $display("FAIL add_sticky: got %b expected 1", m_sticky); end
        tests_run++;
        if ({s_result, s_ovf} !== {r.sat, r.ovf}) begin
            tests_failed++;
            $display("FAIL sat_result: got %h/%b expected %h/%b", s_result, s_ovf, r.sat, r.ovf);
        end
    endtask

    task automatic test_sub;
        logic [7:0] av [2] = '{8'h05, 8'h80};
        logic [7:0] bv [2] = '{8'h07, 8'h01};
        ref_t r;
        int lm, l1, l8, dc;
        for (int k = 0; k < 2; k++) begin
            load_ab(av[k], bv[k]);
            r = ref_op(2'b01, av[k], bv[k], exp_res);
            run_op(2'b01, lm, l1, l8, dc);
            exp_res = r.res;
            tests_run++;
            if ({m_carry, m_ovf, m_result} !== {r.carry, r.ovf, r.res}) begin
                tests_failed++;
                $display("FAIL sub_%0d: got c=%b o=%b r=%h expected c=%b o=%b r=%h",
                         k, m_carry, m_ovf, m_result, r.carry, r.ovf, r.res);
            end
        end
    endtask

    task automatic test_acc_back_to_back;
        ref_t r;
        int lm, l1, l8, dc, n;
        load_ab(8'h10, 8'h20);
        r = ref_op(2'b00, 8'h10, 8'h20, exp_res);
        run_op(2'b00, lm, l1, l8, dc);
        exp_res = r.res;
        tests_run++;
        if (m_result !== r.res) begin tests_failed++; $display("FAIL acc_base: got %h expected %h", m_result, r.res); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        tests_run++;
        if (m_sticky !== 1'b0) begin tests_failed++; $display("FAIL acc_clr: got %b expected 0", m_sticky); end
        for (int k = 0; k < 3; k++) begin
            r = ref_op(2'b10, 8'h00, 8'h20, exp_res);
            op = 2'b10; start = 1'b1; tick(); start = 1'b0;
            n = 1;
            while (!m_done && n < 12) begin tick(); n++; end
            n = m_done ? n - 1 : -1;
            exp_res = r.res;
            tests_run++;
            if ({m_ovf, m_result, n} !== {r.ovf, r.res, 32'sd4}) begin
                tests_failed++;
                $display("FAIL acc_%0d: got o=%b r=%h lat=%0d expected o=%b r=%h lat=4",
                         k, m_ovf, m_result, n, r.ovf, r.res);
            end
        end
        tick(); tick(); tick();
        tests_run++;
        if (m_sticky !== 1'b1) begin tests_failed++; $display("FAIL acc_sticky_hold: got %b expected 1", m_sticky); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        tests_run++;
        if (m_sticky !== 1'b0) begin tests_failed++; $display("FAIL acc_sticky_clr: got %b expected 0", m_sticky); end
    endtask

    task automatic test_ignore_in_calc;
        ref_t r;
        int dc;
        load_ab(8'h10, 8'h20);
        r = ref_op(2'b00, 8'h10, 8'h20, exp_res);
        op = 2'b00; start = 1'b1; tick(); start = 1'b0;
        tick();
        data_in = 8'hAA; load_a = 1'b1; start = 1'b1; op = 2'b01;
        tick();
        load_a = 1'b0; start = 1'b0; op = 2'b00;
        dc = 0;
        for (int n = 0; n < 12; n++) begin tick(); if (m_done) dc++; end
        exp_res = r.res;
        tests_run++;
        if ({m_reg_a, m_result, dc} !== {8'h10, r.res, 32'sd1}) begin
            tests_failed++;
            $display("FAIL calc_ignore: got a=%h r=%h dones=%0d expected a=10 r=%h dones=1",
                     m_reg_a, m_result, dc, r.res);
        end
        // clr_ovf landing on the same edge as an overflowing done.
        load_ab(8'h7F, 8'h01);
        r = ref_op(2'b00, 8'h7F, 8'h01, exp_res);
        op = 2'b00; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        exp_res = r.res;
        tests_run++;
        if ({m_done, m_ovf, m_sticky} !== {1'b1, r.ovf, 1'b1}) begin
            tests_failed++;
            $display("FAIL set_beats_clr: got done=%b o=%b sticky=%b expected 1 %b 1",
                     m_done, m_ovf, m_sticky, r.ovf);
        end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        tests_run++;
        if (m_sticky !== 1'b0) begin tests_failed++; $display("FAIL clr_only: got %b expected 0", m_sticky); end
    endtask

    task automatic test_reset_during_calc;
        ref_t r;
        int lm, l1, l8, dc;
        load_ab(8'h33, 8'h44);
        op = 2'b00; start = 1'b1; tick(); start = 1'b0;
        tick();
        #2 RST = 1'b1;
        #1;
        tests_run++;
        if ({m_busy, m_done, m_carry, m_ovf, m_sticky, m_result, m_reg_a} !== 21'h0) begin
            tests_failed++;
            $display("FAIL rst_calc: got busy=%b done=%b r=%h a=%h expected all zero",
                     m_busy, m_done, m_result, m_reg_a);
        end
        RST = 1'b0;
        exp_res = 8'h00;
        dc = 0;
        for (int n = 0; n < 10; n++) begin tick(); if (m_done) dc++; end
        tests_run++;
        if (dc !== 0) begin tests_failed++; $display("FAIL rst_no_done: got %0d expected 0", dc); end
        load_ab(8'h01, 8'h01);
        r = ref_op(2'b00, 8'h01, 8'h01, exp_res);
        run_op(2'b00, lm, l1, l8, dc);
        exp_res = r.res;
        tests_run++;
        if (m_result !== r.res) begin tests_failed++; $display("FAIL rst_fresh_add: got %h expected %h", m_result, r.res); end
    endtask

    task automatic test_random;
        ref_t r;
        logic [1:0] o;
        logic [7:0] a, b;
        int lm, l1, l8, dc;
        for (int k = 0; k < 24; k++) begin
            o = 2'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            load_ab(a, b);
            r = ref_op(o, a, b, exp_res);
            run_op(o, lm, l1, l8, dc);
            exp_res = r.res;
            tests_run++;
            if ({m_carry, m_ovf, m_result, s_result} !== {r.carry, r.ovf, r.res, r.sat}) begin
                tests_failed++;
                $display("FAIL rand_d2 op=%b a=%h b=%h: got c=%b o=%b r=%h s=%h expected c=%b o=%b r=%h s=%h",
                         o, a, b, m_carry, m_ovf, m_result, s_result, r.carry, r.ovf, r.res, r.sat);
            end
            tests_run++;
            if ({d1_carry, d1_ovf, d1_result, d8_carry, d8_ovf, d8_result} !==
                {r.carry, r.ovf, r.res, r.carry, r.ovf, r.res}) begin
                tests_failed++;
                $display("FAIL rand_d1_d8 op=%b a=%h b=%h: got %b%b%h / %b%b%h expected %b%b%h",
                         o, a, b, d1_carry, d1_ovf, d1_result, d8_carry, d8_ovf, d8_result,
                         r.carry, r.ovf, r.res);
            end
            tests_run++;
            if ({lm, l1, l8} !== {32'sd4, 32'sd8, 32'sd1}) begin
                tests_failed++;
                $display("FAIL rand_latency: got %0d/%0d/%0d expected 4/8/1", lm, l1, l8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_acc_back_to_back();
        test_ignore_in_calc();
        test_reset_during_calc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
